// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: FSM states, default
// frame constants and CMD field layout.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_DATA,
    ST_GET_SUM,
    ST_EXEC,
    ST_TX_REQ,
    ST_TX_START,
    ST_TX_WAIT
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0]  DEF_ACK_BYTE  = 8'h4B;
  localparam logic [7:0]  DEF_NAK_BYTE  = 8'h45;
  localparam int unsigned DEF_TIMEOUT   = 43400;

  localparam int unsigned CMD_WR_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 3;
  localparam int unsigned CMD_ADDR_LSB = 0;

  function automatic logic [7:0] frame_sum(input logic [7:0] sync,
                                           input logic [7:0] cmd,
                                           input logic [7:0] data);
    return sync ^ cmd ^ data;
  endfunction

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

  function automatic logic [3:0] cmd_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, and flags
// expiry combinationally on the cycle the count reaches TIMEOUT-1.
module uart_cmd_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk100,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a stalled enable can never wrap into a false expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame controller: parses SYNC/CMD/DATA/SUM frames, performs a
// register read or write and returns one reply byte through the transmitter.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter logic [7:0]  ACK_BYTE  = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE  = DEF_NAK_BYTE
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rbyte_ready,
  input  logic       busy,
  output logic [7:0] sbyte,
  output logic       send,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] sbyte_q, sbyte_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic [3:0] reg_addr_q, reg_addr_d;
  logic       send_q, send_d;
  logic       reg_we_q, reg_we_d;
  logic       frame_err_q, frame_err_d;

  logic in_frame, tmr_clr, tmr_expired;

  assign in_frame = state_q inside {ST_GET_CMD, ST_GET_DATA, ST_GET_SUM};
  assign tmr_clr  = rbyte_ready || !in_frame;

  uart_cmd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk100  (clk100),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (in_frame),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    sum_d       = sum_q;
    sbyte_d     = sbyte_q;
    reg_wdata_d = reg_wdata_q;
    reg_addr_d  = reg_addr_q;
    send_d      = 1'b0;
    reg_we_d    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rbyte_ready && (rx_byte == SYNC_BYTE)) begin
          state_d = ST_GET_CMD;
        end
      end
      ST_GET_CMD: begin
        if (tmr_expired) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rbyte_ready) begin
          cmd_d   = rx_byte;
          state_d = ST_GET_DATA;
        end
      end
      ST_GET_DATA: begin
        if (tmr_expired) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rbyte_ready) begin
          data_d  = rx_byte;
          state_d = ST_GET_DATA == state_q ? ST_GET_SUM : state_q;
        end
      end
      ST_GET_SUM: begin
        if (tmr_expired) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rbyte_ready) begin
          sum_d      = rx_byte;
          // Address is presented during EXEC so reg_rdata is valid there.
          reg_addr_d = cmd_addr(cmd_q);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_TX_REQ;
        if (sum_q != frame_sum(SYNC_BYTE, cmd_q, data_q)) begin
          frame_err_d = 1'b1;
          sbyte_d     = NAK_BYTE;
        end else if (cmd_is_write(cmd_q)) begin
          reg_we_d    = 1'b1;
          reg_wdata_d = data_q;
          sbyte_d     = ACK_BYTE;
        end else begin
          sbyte_d = reg_rdata;
        end
      end
      ST_TX_REQ: begin
        if (!busy) begin
          send_d  = 1'b1;
          state_d = ST_TX_START;
        end
      end
      ST_TX_START: begin
        state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      sbyte_q     <= '0;
      reg_wdata_q <= '0;
      reg_addr_q  <= '0;
      send_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      sbyte_q     <= sbyte_d;
      reg_wdata_q <= reg_wdata_d;
      reg_addr_q  <= reg_addr_d;
      send_q      <= send_d;
      reg_we_q    <= reg_we_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sbyte     = sbyte_q;
  assign send      = send_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed vector table, multi-cycle
// corner sequences and random frames checked against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int unsigned TO   = 43400;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h4B;
  localparam logic [7:0]  NAK  = 8'h45;

  logic       clk100;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rbyte_ready;
  logic       busy;
  logic [7:0] sbyte;
  logic       send;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       frame_err;

  logic        hold_busy;
  logic        tx_busy;
  int unsigned tx_len;
  int unsigned tx_cnt;
  logic [7:0]  regs [16];
  logic [7:0]  model_regs [16];

  assign busy      = hold_busy | tx_busy;
  assign reg_rdata = regs[reg_addr];

  uart_cmd_ctrl #(
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TO),
    .ACK_BYTE  (ACK),
    .NAK_BYTE  (NAK)
  ) dut (
    .clk100      (clk100),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rbyte_ready (rbyte_ready),
    .busy        (busy),
    .sbyte       (sbyte),
    .send        (send),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .frame_err   (frame_err)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  typedef enum logic [1:0] {EV_WE, EV_SEND, EV_ERR} ev_kind_t;
  typedef struct {
    int unsigned cyc;
    ev_kind_t    kind;
    logic [7:0]  a;
    logic [7:0]  d;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int unsigned cyc;
  int          nchk;
  int          nfail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: cycle counter, event capture, strobe exclusivity, register file.
  initial begin
    cyc = 0;
    for (int i = 0; i < 16; i++) regs[i] = {i[3:0], ~i[3:0]};
    forever begin
      @(posedge clk100);
      cyc++;
      #1;
      if (send || reg_we || frame_err) begin
        chk("strobe_exclusive", 32'(send) + 32'(reg_we) + 32'(frame_err), 32'd1);
        if (reg_we) begin
          obs_q.push_back('{cyc, EV_WE, {4'h0, reg_addr}, reg_wdata});
          regs[reg_addr] = reg_wdata;
        end
        if (send)      obs_q.push_back('{cyc, EV_SEND, 8'h00, sbyte});
        if (frame_err) obs_q.push_back('{cyc, EV_ERR, 8'h00, 8'h00});
      end
    end
  end

  // Transmitter model: busy rises in the send cycle and lasts tx_len cycles.
  initial begin
    tx_busy = 1'b0;
    tx_cnt  = 0;
    forever begin
      @(negedge clk100);
      if (send) tx_cnt = tx_len;
      else if (tx_cnt != 0) tx_cnt--;
      tx_busy = (tx_cnt != 0);
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic put_byte(input logic [7:0] b, output int unsigned s);
    @(negedge clk100);
    rx_byte     = b;
    rbyte_ready = 1'b1;
    s           = cyc;
    @(negedge clk100);
    rbyte_ready = 1'b0;
  endtask

  task automatic cmp_events(input string nm);
    chk($sformatf("%s.count", nm), 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s[%0d].kind", nm, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      chk($sformatf("%s[%0d].cycle", nm, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s[%0d].addr", nm, i), 32'(obs_q[i].a), 32'(exp_q[i].a));
      chk($sformatf("%s[%0d].data", nm, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk($sformatf("%s.sbyte", nm), 32'(sbyte), 32'h0);
    chk($sformatf("%s.send", nm), 32'(send), 32'h0);
    chk($sformatf("%s.reg_we", nm), 32'(reg_we), 32'h0);
    chk($sformatf("%s.reg_addr", nm), 32'(reg_addr), 32'h0);
    chk($sformatf("%s.reg_wdata", nm), 32'(reg_wdata), 32'h0);
    chk($sformatf("%s.frame_err", nm), 32'(frame_err), 32'h0);
  endtask

  // Frame-level model: outcome of a complete frame whose SUM strobe is cycle s.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] data,
                             input logic [7:0] sum, input int unsigned s);
    logic [3:0] a;
    a = cmd[3:0];
    if ((SYNC ^ cmd ^ data) != sum) begin
      exp_q.push_back('{s + 2, EV_ERR, 8'h00, 8'h00});
      exp_q.push_back('{s + 3, EV_SEND, 8'h00, NAK});
    end else if (cmd[7]) begin
      exp_q.push_back('{s + 2, EV_WE, {4'h0, a}, data});
      model_regs[a] = data;
      exp_q.push_back('{s + 3, EV_SEND, 8'h00, ACK});
    end else begin
      exp_q.push_back('{s + 3, EV_SEND, 8'h00, model_regs[a]});
    end
  endtask

  task automatic model_run(input logic [7:0] cmd, input logic [7:0] data,
                           input logic [7:0] sum, input int unsigned gap,
                           input string nm);
    int unsigned s;
    put_byte(SYNC, s);
    idle($urandom_range(0, gap));
    put_byte(cmd, s);
    idle($urandom_range(0, gap));
    put_byte(data, s);
    idle($urandom_range(0, gap));
    put_byte(sum, s);
    model_frame(cmd, data, sum, s);
    idle(30);
    cmp_events(nm);
  endtask

  typedef struct packed {
    logic        has_junk;
    logic [7:0]  junk;
    logic [31:0] bytes;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  sb;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int unsigned s, r, nj;
    logic [7:0]  b, cmd, data, sum;

    nchk        = 0;
    nfail       = 0;
    reset       = 1'b1;
    rx_byte     = 8'h00;
    rbyte_ready = 1'b0;
    hold_busy   = 1'b0;
    tx_len      = 6;
    for (int i = 0; i < 16; i++) model_regs[i] = {i[3:0], ~i[3:0]};

    //           junk?  junk   SYNC CMD DATA SUM  we  addr wdata sbyte err
    tbl[0] = '{1'b0, 8'h00, 32'hA58C5A73, 1'b1, 4'hC, 8'h5A, 8'h4B, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 32'hA50300A6, 1'b0, 4'h3, 8'h00, 8'h3C, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 32'hA5811100, 1'b0, 4'h1, 8'h00, 8'h45, 1'b1};
    tbl[3] = '{1'b1, 8'h5A, 32'hA580A580, 1'b1, 4'h0, 8'hA5, 8'h4B, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 32'hA57FFF25, 1'b0, 4'hF, 8'h00, 8'hF0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 32'hA50C00A9, 1'b0, 4'hC, 8'h00, 8'h5A, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 32'hA50200A6, 1'b0, 4'h2, 8'h00, 8'h45, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 32'hA5F53C6C, 1'b1, 4'h5, 8'h3C, 8'h4B, 1'b0};

    idle(3);
    reset = 1'b0;
    idle(1);
    chk_reset_outs("reset_state");

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].has_junk) begin
        put_byte(tbl[v].junk, s);
        idle(1);
      end
      for (int k = 0; k < 4; k++) begin
        b = tbl[v].bytes[31 - 8*k -: 8];
        put_byte(b, s);
      end
      if (tbl[v].err) exp_q.push_back('{s + 2, EV_ERR, 8'h00, 8'h00});
      if (tbl[v].we) begin
        exp_q.push_back('{s + 2, EV_WE, {4'h0, tbl[v].addr}, tbl[v].wdata});
        model_regs[tbl[v].addr] = tbl[v].wdata;
      end
      exp_q.push_back('{s + 3, EV_SEND, 8'h00, tbl[v].sb});
      idle(25);
      cmp_events($sformatf("vec%0d", v));
    end

    // Timeout after SYNC,CMD; then a normal frame must still complete.
    put_byte(SYNC, s);
    put_byte(8'h81, s);
    exp_q.push_back('{s + TO + 1, EV_ERR, 8'h00, 8'h00});
    idle(TO + 10);
    cmp_events("timeout");
    model_run(8'h8A, 8'h77, SYNC ^ 8'h8A ^ 8'h77, 3, "after_timeout");

    // busy held high on entry to TX_REQ; frame during TX_WAIT is dropped.
    hold_busy = 1'b1;
    tx_len    = 40;
    put_byte(SYNC, s);
    put_byte(8'h85, s);
    put_byte(8'h33, s);
    put_byte(8'h13, s);
    exp_q.push_back('{s + 2, EV_WE, 8'h05, 8'h33});
    model_regs[5] = 8'h33;
    idle(20);
    cmp_events("busy_hold");
    @(negedge clk100);
    hold_busy = 1'b0;
    r = cyc;
    exp_q.push_back('{r + 1, EV_SEND, 8'h00, ACK});
    idle(5);
    put_byte(SYNC, s);
    put_byte(8'h86, s);
    put_byte(8'h44, s);
    put_byte(8'h67, s);
    idle(50);
    cmp_events("busy_release");
    tx_len = 6;
    model_run(8'h06, 8'h00, SYNC ^ 8'h06, 0, "dropped_check");

    // Reset between DATA and SUM aborts the frame.
    put_byte(SYNC, s);
    put_byte(8'h8C, s);
    put_byte(8'h5A, s);
    @(negedge clk100);
    reset = 1'b1;
    @(negedge clk100);
    reset = 1'b0;
    chk_reset_outs("mid_reset");
    put_byte(8'h73, s);
    idle(25);
    cmp_events("reset_abort");
    model_run(8'h8C, 8'h5A, 8'h73, 1, "after_reset");

    for (int n = 0; n < 40; n++) begin
      tx_len = $urandom_range(2, 10);
      nj     = $urandom_range(0, 2);
      for (int j = 0; j < int'(nj); j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        put_byte(b, s);
        idle($urandom_range(0, 3));
      end
      cmd  = 8'($urandom);
      data = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      sum  = SYNC ^ cmd ^ data;
      if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
      model_run(cmd, data, sum, 4, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #950000;
    nfail++;
    $display("FAIL watchdog: reached cycle %0d, limit 95000", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter TIMEOUT, default 43400: inter-byte timeout in clk100 cycles, about 10 byte times at 230400 bps.
REQ-003 Parameter ACK_BYTE, default 8'h4B: write acknowledge.
REQ-004 Parameter NAK_BYTE, default 8'h45: checksum error reply.
REQ-005 Port list, one per line (name, direction, width, meaning):
- clk100 input 1: 100 MHz clock; the block uses this single clock.
- reset input 1: synchronous, active-high reset.
- rx_byte input 8: received UART byte.
- rbyte_ready input 1: one-cycle strobe; rx_byte is valid on this cycle.
- busy input 1: UART transmitter busy.
- sbyte output 8: byte to transmit.
- send output 1: one-cycle transmit request.
- reg_we output 1: one-cycle register write strobe.
- reg_addr output 4: register address.
- reg_wdata output 8: register write data.
- reg_rdata input 8: combinational read data for reg_addr.
- frame_err output 1: one-cycle pulse on a checksum error or a timeout.

Function
REQ-006 Frame format, 4 bytes: SYNC_BYTE, CMD, DATA, SUM.
- CMD[7]=1 means write, CMD[7]=0 means read.
- CMD[3:0] is the address; CMD[6:4] is ignored.
- SUM is the XOR of SYNC_BYTE, CMD and DATA.
REQ-007 States: IDLE, GET_CMD, GET_DATA, GET_SUM, EXEC, TX_REQ, TX_START, TX_WAIT.
REQ-008 IDLE: on rbyte_ready with rx_byte==SYNC_BYTE, go to GET_CMD. Any other byte is discarded and the state stays IDLE.
REQ-009 GET_CMD, GET_DATA, GET_SUM: each rbyte_ready latches the byte and advances one state. A SYNC_BYTE value received here is treated as ordinary data, not as a resync.
REQ-010 A timeout counter clears on entry to GET_CMD and on every rbyte_ready.
- It counts while in GET_CMD, GET_DATA or GET_SUM.
- At count == TIMEOUT-1: go to IDLE, pulse frame_err, transmit nothing.
REQ-011 GET_SUM going to EXEC takes 1 cycle after the SUM strobe. EXEC compares SUM against the computed XOR.
REQ-012 EXEC, checksum bad: pulse frame_err, load sbyte=NAK_BYTE, go to TX_REQ. No register access occurs.
REQ-013 EXEC, good write: pulse reg_we for exactly one cycle with reg_addr=CMD[3:0] and reg_wdata=DATA. Load sbyte=ACK_BYTE and go to TX_REQ.
REQ-014 EXEC, good read: drive reg_addr=CMD[3:0], capture reg_rdata into sbyte in the same cycle, go to TX_REQ.
REQ-015 TX_REQ: when busy==0, assert send for one cycle and go to TX_START. While busy==1, stay in TX_REQ without asserting send.
REQ-016 TX_START: one cycle, busy is ignored (it rises one cycle after send); then go to TX_WAIT.
REQ-017 TX_WAIT: go to IDLE on busy==0.
REQ-018 rbyte_ready strobes that arrive in EXEC, TX_REQ, TX_START or TX_WAIT are dropped.
REQ-019 sbyte stays stable from its load in EXEC until the state leaves TX_START.
REQ-020 Latency, write frame: reg_we is asserted 2 cycles after the SUM strobe; send is asserted 3 cycles after the SUM strobe if busy==0.
REQ-021 send, reg_we and frame_err are never asserted in the same cycle as each other, except that frame_err and the NAK load may coincide in EXEC.

Reset
REQ-022 On reset=1 at a rising edge of clk100:
- state goes to IDLE;
- the timeout counter, send, reg_we and frame_err go to 0;
- sbyte, reg_addr and reg_wdata go to 8'h00, 4'h0 and 8'h00.
REQ-023 Reset mid-frame or mid-transmit aborts immediately. No send or reg_we is issued in the cycle reset is asserted or the cycle after it.

Structure
REQ-024 A shared package uart_cmd_pkg SHALL hold:
- the state enumeration;
- SYNC_BYTE, ACK_BYTE, NAK_BYTE and the default TIMEOUT;
- the CMD field positions: write bit 7, address bits 3:0.
REQ-025 One sub-module, uart_cmd_timer, SHALL implement the timeout counter (clear, enable, expire pulse). All other logic is flat.

Verification
REQ-026 Write frame A5,8C,5A,(A5^8C^5A) with busy=0 -> reg_we pulse with addr=C, wdata=5A; send pulse with sbyte=4B; return to IDLE after busy falls.
REQ-027 Read frame A5,03,00,A6 with reg_rdata=3C -> no reg_we; send with sbyte=3C.
REQ-028 Write frame A5,81,11,00 (bad SUM) -> frame_err pulse; no reg_we; send with sbyte=45.
REQ-029 A5,81 then silence for 43400 cycles -> frame_err pulse at that cycle; no send; IDLE. A following valid frame completes normally.
REQ-030 busy held at 1 when TX_REQ is entered -> send withheld until busy=0. A frame delivered during TX_WAIT is dropped.
REQ-031 reset asserted between DATA and SUM -> IDLE; the subsequent SUM byte is ignored; no reg_we and no send.
